hack_cpu_core: RTL
==================

# hack_cpu_core

Multi-cycle Hack CPU control core: fetches 16-bit Hack instructions, decodes A- and C-instructions, owns the A, D and PC registers, drives the `alu` control bits and operands, and consumes its result. Sits between instruction ROM / data RAM ports and the `alu`. Memory ports use valid/ready-style handshakes so ROM and RAM may stall.

## Interface
- `RESET_PC`, default 15'h0000: PC value loaded on reset.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_req`  out  1  instruction fetch request.
- `instr_addr`  out  15  fetch address (= PC).
- `instr_valid`  in  1  `instr_data` valid for the current request.
- `instr_data`  in  16  fetched instruction.
- `mem_re`  out  1  data read request.
- `mem_we`  out  1  data write request.
- `mem_addr`  out  15  data address.
- `mem_wdata`  out  16  write data.
- `mem_rdata`  in  16  read data.
- `mem_ready`  in  1  completes the current read or write.
- `retired`  out  32  retired-instruction count; present only with `HACK_CPU_PERF_EN`.

## Operation
- FSM states: FETCH, MREAD, EXEC, MWRITE.
- FETCH: `instr_req`=1 with `instr_addr`=PC. On `instr_valid`, latch IR.
  - Next state is MREAD if IR is a C-instruction with a=1.
  - Otherwise next state is EXEC.
- MREAD: `mem_re`=1, `mem_addr`=A[14:0]. On `mem_ready`, latch `mem_rdata` into M, then go to EXEC.
- EXEC lasts one cycle.
- A-instruction (IR[15]=0):
  - A ← {1'b0, IR[14:0]}.
  - PC ← PC+1.
- C-instruction (IR[15]=1; IR[14:13] ignored):
  - ALU x = D; y = (IR[12] ? M : A).
  - ALU controls: zx,nx,zy,ny,f,no = IR[11:6].
  - d bits: IR[5] writes A, IR[4] writes D, IR[3] writes M.
  - Flags: neg = alu_out[15]; zero = (alu_out == 0). The core derives both from `out`; the alu `zr`/`ng` ports are not used.
  - Jump taken = (IR[2]&neg) | (IR[1]&zero) | (IR[0]&~neg&~zero).
  - PC ← taken ? old A[14:0] : PC+1.
  - If IR[3]: capture `mem_addr` ← old A[14:0] and `mem_wdata` ← alu_out, then go to MWRITE. Otherwise go to FETCH.
- MWRITE: `mem_we`=1; address and data held stable until `mem_ready`, then go to FETCH.
- An instruction retires on leaving EXEC without M write, or on leaving MWRITE.
- PC is 15 bits; PC+1 wraps 0x7FFF → 0x0000.
- Handshake rules:
  - Requests stay high with address/data stable until their ready/valid is sampled high.
  - `instr_valid` is ignored outside FETCH; `mem_ready` is ignored outside MREAD/MWRITE.
  - Only one of `instr_req`, `mem_re`, `mem_we` is high in any cycle.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, A=0, D=0, IR=0, M=0, `mem_re`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `retired`=0.
- `instr_req` is 0 while `rst_n`=0 and 1 in the first cycle after release.
- Minimum latency with zero-wait memory (ready/valid high in the request's first cycle):
  - A-instruction or C-instruction without M access: 2 cycles.
  - +1 cycle for an M read; +1 cycle for an M write; 4 cycles worst case.
- Each stall cycle adds exactly one cycle.
- A, D and PC update at the EXEC clock edge. M reads in the next instruction observe the completed write.
- Reset mid-operation (any state, including a pending MREAD/MWRITE): the next cycle shows reset values; the pending transfer is abandoned with no further strobes.

## Configuration
- `HACK_CPU_PERF_EN` defined: `retired` port exists; 32-bit counter, +1 per retirement, wraps at 2^32, cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package `hack_pkg`:
  - FSM state enum.
  - Instruction field positions: a bit, comp[5:0], dest A/D/M, jump LT/EQ/GT.
  - PC width constant (15).
- One sub-module: the existing `alu`, instantiated once. Decode, flags and jump logic stay inline.

## Test plan
- 0x0005 then 0xEC10 (D=A), zero-wait → D=0x0005, PC 0→2 after 4 cycles, no `mem_re`/`mem_we`.
- @100 (0x0064), D=5, then 0xE308 (M=D), `mem_ready` delayed 3 cycles → `mem_we` held 4 cycles with `mem_addr`=100, `mem_wdata`=5; one pulse only.
- 0xFC10 (D=M) with A=100, `mem_rdata`=0x8000, 2-cycle ready delay → D=0x8000, `mem_re` held until ready.
- D=0x8000, 0x000A, then 0xE304 (D;JLT) → PC=10. Repeat with 0xE301 (D;JGT) → PC=PC+1.
- PC=0x7FFF executing 0x0001 → PC=0x0000. 0xEA87 (0;JMP) with A=0x1234 → PC=0x1234.
- `rst_n` low during an MWRITE stall → next cycle `mem_we`=0, PC=RESET_PC, A=D=0, and (with PERF) `retired`=0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared FSM state, instruction field positions and PC width for the Hack CPU core.
package hack_pkg;

  localparam int unsigned PC_W = 15;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_MREAD  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_MWRITE = 2'd3
  } state_e;

  localparam int unsigned IR_CI      = 15;
  localparam int unsigned IR_A       = 12;
  localparam int unsigned IR_COMP_HI = 11;
  localparam int unsigned IR_COMP_LO = 6;
  localparam int unsigned IR_DA      = 5;
  localparam int unsigned IR_DD      = 4;
  localparam int unsigned IR_DM      = 3;
  localparam int unsigned IR_JLT     = 2;
  localparam int unsigned IR_JEQ     = 1;
  localparam int unsigned IR_JGT     = 0;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/hack_cpu_core_if.sv
// Instruction-ROM and data-RAM port bundle; ROM stalls via instr_valid, RAM via mem_ready.
interface hack_cpu_core_if;
  import hack_pkg::*;

  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic            instr_valid;
  logic [15:0]     instr_data;
  logic            mem_re;
  logic            mem_we;
  logic [PC_W-1:0] mem_addr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_rdata;
  logic            mem_ready;

  modport master (
    output instr_req, instr_addr, mem_re, mem_we, mem_addr, mem_wdata,
    input  instr_valid, instr_data, mem_rdata, mem_ready
  );

  modport slave (
    input  instr_req, instr_addr, mem_re, mem_we, mem_addr, mem_wdata,
    output instr_valid, instr_data, mem_rdata, mem_ready
  );

endinterface

// File: rtl/hack_cpu_core_alu.sv
// Hack ALU: combinational, zero latency, no backpressure.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x0, x1, y0, y1, r;

  assign x0  = zx ? 16'h0000 : x;
  assign x1  = nx ? ~x0 : x0;
  assign y0  = zy ? 16'h0000 : y;
  assign y1  = ny ? ~y0 : y0;
  assign r   = f ? (x1 + y1) : (x1 & y1);
  assign out = no ? ~r : r;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];

endmodule

// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU: 2 cycles per instruction, +1 per M read/write, +1 per ROM/RAM stall cycle.
// Optional HACK_CPU_PERF_EN adds the 32-bit `retired` instruction counter port.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  hack_cpu_core_if.master bus
`ifdef HACK_CPU_PERF_EN
  ,
  output logic [31:0]     retired
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     d_q, d_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     m_q, m_d;
  logic [PC_W-1:0] maddr_q, maddr_d;
  logic [15:0]     wdata_q, wdata_d;

  logic [5:0]  comp;
  logic [15:0] alu_y, alu_out;
  logic [1:0]  unused_flags;
  logic        is_c, wr_m, neg, zero, taken, retire;

  assign is_c  = ir_q[IR_CI];
  assign wr_m  = is_c & ir_q[IR_DM];
  assign comp  = ir_q[IR_COMP_HI:IR_COMP_LO];
  assign alu_y = ir_q[IR_A] ? m_q : a_q;

  alu u_alu (
    .x  (d_q),
    .y  (alu_y),
    .zx (comp[5]),
    .nx (comp[4]),
    .zy (comp[3]),
    .ny (comp[2]),
    .f  (comp[1]),
    .no (comp[0]),
    .out(alu_out),
    .zr (unused_flags[0]),
    .ng (unused_flags[1])
  );

  assign neg   = alu_out[15];
  assign zero  = (alu_out == 16'h0000);
  assign taken = (ir_q[IR_JLT] & neg) | (ir_q[IR_JEQ] & zero) | (ir_q[IR_JGT] & ~neg & ~zero);
  assign retire = ((state_q == ST_EXEC) && !wr_m) || ((state_q == ST_MWRITE) && bus.mem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          state_d = (bus.instr_data[IR_CI] & bus.instr_data[IR_A]) ? ST_MREAD : ST_EXEC;
        end
      end
      ST_MREAD:  if (bus.mem_ready) state_d = ST_EXEC;
      ST_EXEC:   state_d = wr_m ? ST_MWRITE : ST_FETCH;
      ST_MWRITE: if (bus.mem_ready) state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Fetch is masked during reset so no request escapes before state is known.
  always_comb begin
    bus.instr_req  = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.instr_addr = pc_q;
    bus.mem_addr   = maddr_q;
    bus.mem_wdata  = wdata_q;
    case (state_q)
      ST_FETCH: bus.instr_req = rst_n;
      ST_MREAD: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = a_q[PC_W-1:0];
      end
      ST_MWRITE: bus.mem_we = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_FETCH: if (bus.instr_valid) ir_d = bus.instr_data;
      ST_MREAD: if (bus.mem_ready) m_d = bus.mem_rdata;
      ST_EXEC: begin
        if (!is_c) begin
          a_d  = {1'b0, ir_q[PC_W-1:0]};
          pc_d = pc_inc(pc_q);
        end else begin
          if (ir_q[IR_DA]) a_d = alu_out;
          if (ir_q[IR_DD]) d_d = alu_out;
          // Write address and jump target both use A as it was before this instruction.
          if (ir_q[IR_DM]) begin
            maddr_d = a_q[PC_W-1:0];
            wdata_d = alu_out;
          end
          pc_d = taken ? a_q[PC_W-1:0] : pc_inc(pc_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      m_q     <= m_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef HACK_CPU_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
